// File: rtl/multicycle_ctrl_if.sv
// Memory-port handshake between the multi-cycle control FSM and the shared memory.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences FETCH/DECODE/EXECUTE/MEM/WB,
// drives per-state enables and mux selects, watches memory timeouts and illegal opcodes,
// and counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  multicycle_ctrl_if.master    mem,
  input  logic [6:0]           opcode,
  input  logic                 branch_cond,
  output logic                 ir_we,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic [1:0]           alu_a_sel,
  output logic                 alu_b_sel,
  output logic                 halted,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [CNT_W-1:0]     instret
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT, S_TRAP
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Watchdog holds the number of wait cycles already spent; it trips on the cycle where
  // it equals MEM_TIMEOUT-1 and mem_ready is still low.
  localparam int unsigned     WD_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [1:0]       cause_q, cause_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;

  logic req_s, we_s, irwe_s, rfwe_s, pcwe_s, addr_sel_s;
  logic is_op, is_opimm, is_lui, is_auipc, is_load, is_store, is_branch, is_jal, is_jalr;
  logic is_legal, timeout;

  // Opcode classification and watchdog trip condition.
  always_comb begin
    is_op     = (opcode == OPC_OP);
    is_opimm  = (opcode == OPC_OPIMM);
    is_lui    = (opcode == OPC_LUI);
    is_auipc  = (opcode == OPC_AUIPC);
    is_load   = (opcode == OPC_LOAD);
    is_store  = (opcode == OPC_STORE);
    is_branch = (opcode == OPC_BRANCH);
    is_jal    = (opcode == OPC_JAL);
    is_jalr   = (opcode == OPC_JALR);
    is_legal  = is_op | is_opimm | is_lui | is_auipc | is_load | is_store |
                is_branch | is_jal | is_jalr;
    timeout   = (MEM_TIMEOUT != 0) && (wdog_q == WD_LAST);
  end

  // Next-state, Moore selects and raw strobes; strobes are gated by reset afterwards.
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    wdog_d     = '0;
    req_s      = 1'b0;
    we_s       = 1'b0;
    irwe_s     = 1'b0;
    rfwe_s     = 1'b0;
    pcwe_s     = 1'b0;
    addr_sel_s = 1'b0;
    wb_sel     = 2'd0;
    pc_sel     = 2'd0;
    alu_a_sel  = 2'd0;
    alu_b_sel  = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        req_s = 1'b1;
        if (mem.mem_ready) begin
          irwe_s  = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else if (MEM_TIMEOUT != 0) begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXECUTE;
        end else if (opcode == OPC_SYSTEM) begin
          state_d = S_HALT;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end
      end
      S_EXECUTE: begin
        if (is_opimm | is_load | is_store | is_jalr) begin
          alu_b_sel = 1'b1;
        end else if (is_auipc) begin
          alu_a_sel = 2'd1;
          alu_b_sel = 1'b1;
        end else if (is_lui) begin
          alu_a_sel = 2'd2;
          alu_b_sel = 1'b1;
        end
        if (is_branch) begin
          pcwe_s  = 1'b1;
          pc_sel  = branch_cond ? 2'd1 : 2'd0;
          state_d = S_FETCH;
        end else if (is_load | is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        req_s      = 1'b1;
        addr_sel_s = 1'b1;
        we_s       = is_store;
        if (mem.mem_ready) begin
          if (is_store) begin
            pcwe_s  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else if (MEM_TIMEOUT != 0) begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_WB: begin
        rfwe_s  = 1'b1;
        pcwe_s  = 1'b1;
        state_d = S_FETCH;
        if (is_load) begin
          wb_sel = 2'd1;
        end else if (is_jal) begin
          wb_sel = 2'd2;
          pc_sel = 2'd1;
        end else if (is_jalr) begin
          wb_sel = 2'd2;
          pc_sel = 2'd2;
        end
      end
      S_HALT, S_TRAP: begin
        state_d = state_q;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Strobes are forced low during reset so an aborted request never commits anything.
    ir_we     = irwe_s & ~reset;
    rf_we     = rfwe_s & ~reset;
    pc_we     = pcwe_s & ~reset;
    instret_d = instret_q + (pc_we ? CNT_W'(1) : CNT_W'(0));
  end

  assign mem.mem_req      = req_s & ~reset;
  assign mem.mem_we       = we_s & ~reset;
  assign mem.mem_addr_sel = addr_sel_s;
  assign halted           = (state_q == S_HALT) || (state_q == S_TRAP);
  assign trap             = (state_q == S_TRAP);
  assign trap_cause       = cause_q;
  assign instret          = instret_q;

  // State, retire counter, trap cause and watchdog registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      cause_q   <= '0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      cause_q   <= cause_d;
      wdog_q    <= wdog_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected control vectors go through a
// scoreboard queue and are compared at the falling edge.
module tb_multicycle_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst1, rst2, bc, use2;
  logic [6:0] op1, op2;

  multicycle_ctrl_if bus1 ();
  multicycle_ctrl_if bus2 ();

  logic        ir_we1, rf_we1, pc_we1, b_sel1, halted1, trap1;
  logic [1:0]  wb_sel1, pc_sel1, a_sel1, cause1;
  logic [31:0] instret1;
  logic        ir_we2, rf_we2, pc_we2, b_sel2, halted2, trap2;
  logic [1:0]  wb_sel2, pc_sel2, a_sel2, cause2;
  logic [7:0]  instret2;

  multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) u_dut (
    .clock(clock), .reset(rst1), .mem(bus1.master), .opcode(op1), .branch_cond(bc),
    .ir_we(ir_we1), .rf_we(rf_we1), .wb_sel(wb_sel1), .pc_we(pc_we1), .pc_sel(pc_sel1),
    .alu_a_sel(a_sel1), .alu_b_sel(b_sel1), .halted(halted1), .trap(trap1),
    .trap_cause(cause1), .instret(instret1)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) u_wd (
    .clock(clock), .reset(rst2), .mem(bus2.master), .opcode(op2), .branch_cond(bc),
    .ir_we(ir_we2), .rf_we(rf_we2), .wb_sel(wb_sel2), .pc_we(pc_we2), .pc_sel(pc_sel2),
    .alu_a_sel(a_sel2), .alu_b_sel(b_sel2), .halted(halted2), .trap(trap2),
    .trap_cause(cause2), .instret(instret2)
  );

  // {mem_req, mem_we, mem_addr_sel, ir_we, rf_we, wb_sel, pc_we, pc_sel, a_sel, b_sel,
  //  halted, trap, trap_cause}
  logic [16:0] obs1, obs2;
  assign obs1 = {bus1.mem_req, bus1.mem_we, bus1.mem_addr_sel, ir_we1, rf_we1, wb_sel1,
                 pc_we1, pc_sel1, a_sel1, b_sel1, halted1, trap1, cause1};
  assign obs2 = {bus2.mem_req, bus2.mem_we, bus2.mem_addr_sel, ir_we2, rf_we2, wb_sel2,
                 pc_we2, pc_sel2, a_sel2, b_sel2, halted2, trap2, cause2};

  int tests = 0;
  int fails = 0;

  logic [16:0] exp_q[$];
  string       tag_q[$];

  function automatic logic [16:0] v(logic mreq, logic mwe, logic masel, logic irwe,
                                    logic rfwe, logic [1:0] wbs, logic pcwe, logic [1:0] pcs,
                                    logic [1:0] as, logic bs, logic h, logic t,
                                    logic [1:0] c);
    return {mreq, mwe, masel, irwe, rfwe, wbs, pcwe, pcs, as, bs, h, t, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after posedge, push expectation, compare at negedge.
  task automatic cyc(input string tag, input logic r, input logic rdy, input logic b,
                     input logic [16:0] exp);
    logic [16:0] o;
    logic [16:0] e;
    string       t;
    if (use2) begin
      rst2 = r;
      bus2.mem_ready = rdy;
    end else begin
      rst1 = r;
      bus1.mem_ready = rdy;
    end
    bc = b;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clock);
    o = use2 ? obs2 : obs1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, {15'b0, o}, {15'b0, e});
    @(posedge clock);
    #1;
  endtask

  logic [16:0] ZERO, F_W, F_R, EX_IMM, WB_ALU, WB_LD, WB_JR, M_RD, M_ST_W, M_ST_R;
  logic [16:0] BR_T, BR_N, TRAP_ILL, TRAP_TO, HALT_V, RST_MEM;

  initial begin
    ZERO     = '0;
    F_W      = v(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0);
    F_R      = v(1, 0, 0, 1, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0);
    EX_IMM   = v(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 0, 0, 2'd0);
    WB_ALU   = v(0, 0, 0, 0, 1, 2'd0, 1, 2'd0, 2'd0, 0, 0, 0, 2'd0);
    WB_LD    = v(0, 0, 0, 0, 1, 2'd1, 1, 2'd0, 2'd0, 0, 0, 0, 2'd0);
    WB_JR    = v(0, 0, 0, 0, 1, 2'd2, 1, 2'd2, 2'd0, 0, 0, 0, 2'd0);
    M_RD     = v(1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0);
    M_ST_W   = v(1, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0);
    M_ST_R   = v(1, 1, 1, 0, 0, 2'd0, 1, 2'd0, 2'd0, 0, 0, 0, 2'd0);
    BR_T     = v(0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'd0, 0, 0, 0, 2'd0);
    BR_N     = v(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd0, 0, 0, 0, 2'd0);
    TRAP_ILL = v(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 1, 1, 2'd1);
    TRAP_TO  = v(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 1, 1, 2'd2);
    HALT_V   = v(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 1, 0, 2'd0);
    RST_MEM  = v(0, 0, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0);

    use2 = 1'b0;
    rst1 = 1'b1;
    rst2 = 1'b1;
    bc   = 1'b0;
    op1  = 7'b0110011;
    op2  = 7'b0110011;
    bus1.mem_ready = 1'b0;
    bus2.mem_ready = 1'b0;
    @(posedge clock);
    #1;

    // Reset: strobes low even with mem_ready high
    cyc("rst_strobes", 1, 1, 0, ZERO);
    chk("rst_instret", instret1, 32'd0);
    chk("rst_cause", {30'b0, cause1}, 32'd0);

    // ADD, zero-wait fetch: 4 cycles
    op1 = 7'b0110011;
    cyc("add_fetch", 0, 1, 0, F_R);
    cyc("add_decode", 0, 0, 0, ZERO);
    cyc("add_exec", 0, 0, 0, ZERO);
    cyc("add_wb", 0, 0, 0, WB_ALU);
    chk("add_instret", instret1, 32'd1);

    // LOAD, 3 wait cycles in both FETCH and MEM: 11 cycles
    op1 = 7'b0000011;
    for (int i = 0; i < 3; i++) cyc("ld_fetch_wait", 0, 0, 0, F_W);
    cyc("ld_fetch", 0, 1, 0, F_R);
    cyc("ld_decode", 0, 0, 0, ZERO);
    cyc("ld_exec", 0, 0, 0, EX_IMM);
    for (int i = 0; i < 3; i++) cyc("ld_mem_wait", 0, 0, 0, M_RD);
    cyc("ld_mem", 0, 1, 0, M_RD);
    cyc("ld_wb", 0, 0, 0, WB_LD);
    chk("ld_instret", instret1, 32'd2);

    // BRANCH taken then not taken
    op1 = 7'b1100011;
    cyc("br1_fetch", 0, 1, 1, F_R);
    cyc("br1_decode", 0, 0, 1, ZERO);
    cyc("br1_exec", 0, 0, 1, BR_T);
    cyc("br2_fetch", 0, 1, 0, F_R);
    cyc("br2_decode", 0, 0, 0, ZERO);
    cyc("br2_exec", 0, 0, 0, BR_N);
    chk("br_instret", instret1, 32'd4);

    // JALR, then illegal opcode 0000000 traps
    op1 = 7'b1100111;
    cyc("jalr_fetch", 0, 1, 0, F_R);
    cyc("jalr_decode", 0, 0, 0, ZERO);
    cyc("jalr_exec", 0, 0, 0, EX_IMM);
    cyc("jalr_wb", 0, 0, 0, WB_JR);
    chk("jalr_instret", instret1, 32'd5);
    op1 = 7'b0000000;
    cyc("ill_fetch", 0, 1, 0, F_R);
    cyc("ill_decode", 0, 0, 0, ZERO);
    for (int i = 0; i < 20; i++) cyc("ill_trap", 0, i[0], i[1], TRAP_ILL);
    chk("ill_instret", instret1, 32'd5);

    // Reset out of TRAP, complete STORE (4 cycles)
    cyc("rst_from_trap", 1, 0, 0, TRAP_ILL);
    chk("rst2_cause", {30'b0, cause1}, 32'd0);
    op1 = 7'b0100011;
    cyc("st_fetch", 0, 1, 0, F_R);
    cyc("st_decode", 0, 0, 0, ZERO);
    cyc("st_exec", 0, 0, 0, EX_IMM);
    cyc("st_mem", 0, 1, 0, M_ST_R);
    chk("st_instret", instret1, 32'd1);

    // STORE interrupted by reset during MEM wait
    cyc("st2_fetch", 0, 1, 0, F_R);
    cyc("st2_decode", 0, 0, 0, ZERO);
    cyc("st2_exec", 0, 0, 0, EX_IMM);
    cyc("st2_mem_wait", 0, 0, 0, M_ST_W);
    cyc("st2_mem_reset", 1, 1, 0, RST_MEM);
    chk("st2_instret", instret1, 32'd0);
    chk("st2_cause", {30'b0, cause1}, 32'd0);
    cyc("st2_restart", 0, 0, 0, F_W);

    // ECALL halts without trap
    op1 = 7'b1110011;
    cyc("ecall_fetch", 0, 1, 0, F_R);
    cyc("ecall_decode", 0, 0, 0, ZERO);
    for (int i = 0; i < 3; i++) cyc("ecall_halt", 0, 1, 0, HALT_V);
    chk("ecall_instret", instret1, 32'd0);

    // Watchdog with MEM_TIMEOUT=4
    use2 = 1'b1;
    cyc("wd_rst", 1, 0, 0, ZERO);
    for (int i = 0; i < 4; i++) cyc("wd_wait", 0, 0, 0, F_W);
    cyc("wd_trap", 0, 1, 0, TRAP_TO);
    cyc("wd_trap_hold", 0, 0, 0, TRAP_TO);
    chk("wd_cause", {30'b0, cause2}, 32'd2);
    chk("wd_instret", {24'b0, instret2}, 32'd0);
    cyc("wd_rst2", 1, 0, 0, TRAP_TO);
    for (int i = 0; i < 3; i++) cyc("wd2_wait", 0, 0, 0, F_W);
    cyc("wd2_ready_last", 0, 1, 0, F_R);
    cyc("wd2_decode", 0, 0, 0, ZERO);
    cyc("wd2_exec", 0, 0, 0, ZERO);
    cyc("wd2_wb", 0, 0, 0, WB_ALU);
    chk("wd2_instret", {24'b0, instret2}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
